instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: the initiator side of the instruction-memory read port. Drives a word address into the combinational instruction memory, captures the returned word, and hands it to decode through a valid/ready register stage. Owns the program counter, sequential increment by 4, back-pressure stalls and branch/jump redirects.

## Interface
- RESET_PC, 32'd0, PC loaded on reset; must be word aligned
- IMEM_BYTES, 24, size of instruction memory in bytes; used only when bounds checking is compiled in
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- Address  output  32  byte address to instruction memory; always equals current PC
- Instruction  input  32  word returned by instruction memory, valid in the same cycle as Address
- redirect_valid  input  1  load redirect_target into PC this cycle
- redirect_target  input  32  new PC; bits [1:0] ignored (forced to 0)
- if_valid  output  1  if_instr/if_pc hold a fetched instruction
- if_ready  input  1  decode accepts the instruction this cycle
- if_instr  output  32  fetched instruction word
- if_pc  output  32  byte address of if_instr
- fetch_fault  output  1  PC out of range, fetch halted (held 0 when bounds checking compiled out)

## Operation
- Registers: pc, if_valid, if_instr, if_pc, fault state.
- Reset values: pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, fetch_fault=0; Address therefore reads RESET_PC during reset.
- Address = pc, combinational.
- load = !redirect_valid && !fault && (!if_valid || if_ready).
- On load: if_instr<=Instruction, if_pc<=pc, if_valid<=1, pc<=pc+4.
- if_valid && if_ready && !load: if_valid<=0 (drain).
- if_valid && !if_ready: if_instr, if_pc, if_valid and pc all hold (stall); Instruction is re-read next cycle.
- Redirect has top priority: pc<={redirect_target[31:2],2'b00}, if_valid<=0 (flush), no load; fault cleared. A transfer with if_valid&&if_ready in the same cycle still counts as consumed.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- States: RUN (normal) and FAULT (only with macro). RUN->FAULT when load conditions hold but pc >= IMEM_BYTES; no load that cycle, fetch_fault<=1. FAULT->RUN only on redirect_valid or reset. In FAULT, the pending if_valid entry still drains normally.

## Timing
- First instruction: reset deasserts before edge E0; at E0 word at RESET_PC is captured; if_valid=1 after E0.
- Throughput: one instruction per cycle while if_ready=1.
- Fetch latency: 1 cycle (PC to if_instr register).
- Redirect asserted in cycle N: after edge N, pc=target, if_valid=0; target word valid after edge N+1. Exactly one bubble.
- Stall: zero-cycle response; deasserting if_ready freezes outputs at that edge.
- Reset mid-operation: all registers return to reset values immediately, independent of clk.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined: FAULT state and range check against IMEM_BYTES present; fetch_fault asserts as described.
- FETCH_BOUNDS_CHECK_EN undefined: no range check, no FAULT state, fetch_fault tied 0, PC runs freely with wrap-around; IMEM_BYTES unused.

## Test plan
- Memory model returns 10,20,30,40,50,60 at addresses 0,4,...,20; RESET_PC=0, if_ready=1 -> if_instr sequence 10,20,30,40,50,60 with if_pc 0,4,...,20 on consecutive cycles, first if_valid after first edge.
- Hold if_ready=0 for 3 cycles while if_instr=20 -> if_instr=20, if_pc=4, Address=8 held; on release, 20 accepted then 30 next cycle, nothing skipped or duplicated.
- redirect_valid=1, redirect_target=32'h0000_0013 while if_pc=8 valid -> one cycle if_valid=0, then if_pc=16, if_instr=50.
- Redirect in the same cycle as if_valid&&if_ready -> current instruction consumed once, next valid instruction is from target.
- With FETCH_BOUNDS_CHECK_EN, IMEM_BYTES=24: after if_pc=20 (60) -> fetch_fault=1 next edge, Address stuck at 24, no new if_valid; redirect to 0 -> fetch_fault=0, if_instr=10 follows. Without macro: Address advances to 24, 28 and fetching continues.
- Assert reset mid-stream with if_valid=1 -> if_valid, if_instr, if_pc, fetch_fault go to 0 and Address to RESET_PC asynchronously, before next clk edge.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-side bus: instruction-memory read port, redirect request and the
// valid/ready hand-off to decode.
interface instr_fetch_if;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    modport master (
        output Address, if_valid, if_instr, if_pc, fetch_fault,
        input  Instruction, redirect_valid, redirect_target, if_ready
    );

    modport slave (
        input  Address, if_valid, if_instr, if_pc, fetch_fault,
        output Instruction, redirect_valid, redirect_target, if_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives imem, registers one word for decode.
// Define FETCH_BOUNDS_CHECK_EN to add the IMEM_BYTES range check and FAULT state.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_BYTES = 24
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        valid_q, valid_d;
    logic        halted;
    logic        can_load;
    logic        load;

    if (RESET_PC[1:0] != 2'b00 || (IMEM_BYTES % 4) != 0) begin : g_cfg_check
        $error("instr_fetch: RESET_PC and IMEM_BYTES must be word aligned");
    end

    // Output register may refill only when empty or being consumed this cycle.
    assign can_load = !bus.redirect_valid && !halted && (!valid_q || bus.if_ready);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_d    = pc_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        valid_d = valid_q;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_target & ~32'd3;
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = bus.Instruction;
            if_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
        end else if (valid_q && bus.if_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            if_pc_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Address  = pc_q;
    assign bus.if_valid = valid_q;
    assign bus.if_instr = instr_q;
    assign bus.if_pc    = if_pc_q;

`ifdef FETCH_BOUNDS_CHECK_EN
    typedef enum logic {ST_RUN, ST_FAULT} state_t;
    state_t state_q, state_d;
    logic   in_range;

    assign in_range        = pc_q < IMEM_BYTES;
    assign load            = can_load && in_range;
    assign halted          = (state_q == ST_FAULT);
    assign bus.fetch_fault = halted;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (can_load && !in_range) state_d = ST_FAULT;
            ST_FAULT: if (bus.redirect_valid)    state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end
`else
    assign halted          = 1'b0;
    assign load            = can_load;
    assign bus.fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed test-plan sequences plus random
// ready/redirect traffic against a behavioural model and an in-order stream check.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC   = 32'd0;
    localparam int unsigned IMEM_BYTES = 24;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory image: word n holds 10*(n+1), so addresses 0..20 give 10..60.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'd10;
    endfunction

    assign bus.Instruction = mem_word(bus.Address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what decode should see, plus where fetch stands.
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_ifpc  = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic [31:0] exp_next = RESET_PC;   // address decode must receive next

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = RESET_PC; m_instr = 32'd0; m_ifpc = 32'd0;
            m_valid = 1'b0;  m_fault = 1'b0;  exp_next = RESET_PC;
        end else begin
            // Stream check: each consumed word is the right one, in program order.
            if (bus.if_valid && bus.if_ready) begin
                check("stream_pc", bus.if_pc, exp_next);
                check("stream_word", bus.if_instr, mem_word(bus.if_pc));
                exp_next = bus.if_pc + 32'd4;
            end
            if (bus.redirect_valid) exp_next = bus.redirect_target & ~32'd3;

            if (bus.redirect_valid) begin
                m_pc = bus.redirect_target & ~32'd3;
                m_valid = 1'b0;
                m_fault = 1'b0;
            end else if (!m_fault && (!m_valid || bus.if_ready)) begin
                if (BOUNDS && m_pc >= IMEM_BYTES) begin
                    m_fault = 1'b1;
                    m_valid = 1'b0;
                end else begin
                    m_instr = mem_word(m_pc);
                    m_ifpc  = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 32'd4;
                end
            end else if (m_valid && bus.if_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            check("address", bus.Address, m_pc);
            check("if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
            check("fetch_fault", {31'd0, bus.fetch_fault}, {31'd0, m_fault});
            if (m_valid) begin
                check("if_instr", bus.if_instr, m_instr);
                check("if_pc", bus.if_pc, m_ifpc);
            end
        end
    end

    initial begin
        bus.if_ready        = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
        #1 reset = 1'b1;
        #2;
        check("rst_address", bus.Address, RESET_PC);
        check("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_instr", bus.if_instr, 32'd0);
        check("rst_ifpc", bus.if_pc, 32'd0);
        check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
        @(negedge clk) reset = 1'b0;

        // Straight-line fetch of the six-word image.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("seq_valid", {31'd0, bus.if_valid}, 32'd1);
            check("seq_instr", bus.if_instr, 32'(10 * (k + 1)));
            check("seq_pc", bus.if_pc, 32'(4 * k));
        end
        check("seq_addr", bus.Address, 32'd24);

        // Running off the end of the image.
        @(negedge clk);
        if (BOUNDS) begin
            check("oob_fault", {31'd0, bus.fetch_fault}, 32'd1);
            check("oob_valid", {31'd0, bus.if_valid}, 32'd0);
            check("oob_addr", bus.Address, 32'd24);
        end else begin
            check("oob_instr", bus.if_instr, 32'd70);
            check("oob_pc", bus.if_pc, 32'd24);
            check("oob_addr", bus.Address, 32'd28);
        end
        @(negedge clk);
        check("oob_addr2", bus.Address, BOUNDS ? 32'd24 : 32'd32);

        // Redirect to 0 recovers from fault.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'd0;
        @(negedge clk) bus.redirect_valid = 1'b0;
        check("rec_fault", {31'd0, bus.fetch_fault}, 32'd0);
        check("rec_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rec_addr", bus.Address, 32'd0);
        @(negedge clk);
        check("rec_instr", bus.if_instr, 32'd10);
        @(negedge clk);
        check("pre_stall_instr", bus.if_instr, 32'd20);

        // Three-cycle stall on word 20.
        bus.if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_instr", bus.if_instr, 32'd20);
            check("stall_pc", bus.if_pc, 32'd4);
            check("stall_addr", bus.Address, 32'd8);
        end
        bus.if_ready = 1'b1;
        @(negedge clk);
        check("release_instr", bus.if_instr, 32'd30);
        check("release_pc", bus.if_pc, 32'd8);

        // Redirect to 0x13 in the same cycle the word at 8 is consumed.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0013;
        @(negedge clk) bus.redirect_valid = 1'b0;
        check("redir_bubble", {31'd0, bus.if_valid}, 32'd0);
        check("redir_addr", bus.Address, 32'd16);
        @(negedge clk);
        check("redir_pc", bus.if_pc, 32'd16);
        check("redir_instr", bus.if_instr, 32'd50);

        // Random ready / redirect traffic, including targets near the wrap point.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.if_ready       = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0)
                bus.redirect_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                bus.redirect_target = 32'($urandom_range(0, 40));
        end

        // Asynchronous reset with a word held in the output stage.
        @(negedge clk);
        bus.if_ready        = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'd8;
        @(negedge clk) bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("mid_valid", {31'd0, bus.if_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_valid", {31'd0, bus.if_valid}, 32'd0);
        check("async_instr", bus.if_instr, 32'd0);
        check("async_ifpc", bus.if_pc, 32'd0);
        check("async_fault", {31'd0, bus.fetch_fault}, 32'd0);
        check("async_addr", bus.Address, RESET_PC);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        check("restart_instr", bus.if_instr, 32'd10);
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
